// File: rtl/rsnn_step_scheduler.sv
// rsnn_step_scheduler
//
// Sequencer and configuration front-end for one recurrent spiking neuron.
// Byte-wide configuration writes land in shadow registers and are committed
// to the active parameter outputs at step boundaries (or immediately while
// idle). The block issues a one-cycle neuron_enable pulse per step, either
// periodically (ctrl.run) or once on request (ctrl.single_step). It samples
// spike_in in the cycle after each pulse and keeps spike/step statistics.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   cfg_valid/cfg_ready     config write handshake
//   cfg_addr, cfg_data      0 thr, 1 decay, 2 refr, 3 fb_scale, 4 ext_current,
//                           5 period, 6 ctrl {clear, single_step, run}, 7 ignored
//   spike_in                neuron spike output, sampled only in SAMPLE
//   neuron_enable           one-cycle update pulse to the neuron
//   neuron_reset            high while reset is high, and for one cycle after a clear
//   threshold .. external_input_current   active neuron parameters
//   spike_count             saturating spike count
//   step_count              number of enable pulses issued (wraps)
//   busy                    state != IDLE
//   state_dbg               current FSM state
//
// Handshake: a write takes effect on the rising edge where cfg_valid and
// cfg_ready are both high. cfg_ready is low only in COMMIT, so the active
// parameters are never written by the bus and the commit in the same cycle.

module rsnn_step_scheduler #(
  parameter int PERIOD_W   = 8,
  parameter int STEP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [2:0]            cfg_addr,
  input  logic [7:0]            cfg_data,
  input  logic                  spike_in,
  output logic                  neuron_enable,
  output logic                  neuron_reset,
  output logic [7:0]            threshold,
  output logic [7:0]            decay,
  output logic [7:0]            refractory_period,
  output logic [7:0]            feedback_scale,
  output logic [7:0]            external_input_current,
  output logic [7:0]            spike_count,
  output logic [STEP_CNT_W-1:0] step_count,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_COMMIT = 3'd2,
    S_ENABLE = 3'd3,
    S_SAMPLE = 3'd4
  } state_t;

  state_t              state;
  logic [PERIOD_W-1:0] wait_cnt;
  logic                run;
  logic                clr_q;

  logic [7:0]          thr_s, decay_s, refr_s, fb_s, ext_s;
  logic [PERIOD_W-1:0] period_s, period_a;

  logic wr, ctrl_wr, run_eff, step_req, clr_req;

  assign wr       = cfg_valid && cfg_ready;
  assign ctrl_wr  = wr && (cfg_addr == 3'd6);
  // A ctrl write acts on the FSM in the cycle it is accepted, so the
  // decision uses the incoming run bit rather than the stored one.
  assign run_eff  = ctrl_wr ? cfg_data[0] : run;
  assign step_req = ctrl_wr && cfg_data[1];
  assign clr_req  = ctrl_wr && cfg_data[2];

  assign cfg_ready     = (state != S_COMMIT);
  assign neuron_enable = (state == S_ENABLE);
  assign busy          = (state != S_IDLE);
  assign neuron_reset  = reset | clr_q;
  assign state_dbg     = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= S_IDLE;
      wait_cnt               <= '0;
      run                    <= 1'b0;
      clr_q                  <= 1'b0;
      thr_s                  <= 8'd64;
      decay_s                <= 8'd2;
      refr_s                 <= 8'd4;
      fb_s                   <= 8'd0;
      ext_s                  <= 8'd0;
      period_s               <= PERIOD_W'(9);
      threshold              <= 8'd64;
      decay                  <= 8'd2;
      refractory_period      <= 8'd4;
      feedback_scale         <= 8'd0;
      external_input_current <= 8'd0;
      period_a               <= PERIOD_W'(9);
      spike_count            <= 8'd0;
      step_count             <= '0;
    end else begin
      clr_q <= clr_req;

      if (wr) begin
        case (cfg_addr)
          3'd0: thr_s    <= cfg_data;
          3'd1: decay_s  <= cfg_data;
          3'd2: refr_s   <= cfg_data;
          3'd3: fb_s     <= cfg_data;
          3'd4: ext_s    <= cfg_data;
          3'd5: period_s <= PERIOD_W'(cfg_data);
          3'd6: run      <= cfg_data[0];
          default: ;
        endcase
      end

      // While idle there is no step in flight, so writes go straight through.
      if (wr && state == S_IDLE) begin
        case (cfg_addr)
          3'd0: threshold              <= cfg_data;
          3'd1: decay                  <= cfg_data;
          3'd2: refractory_period      <= cfg_data;
          3'd3: feedback_scale         <= cfg_data;
          3'd4: external_input_current <= cfg_data;
          3'd5: period_a               <= PERIOD_W'(cfg_data);
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (run_eff) begin
            state    <= S_WAIT;
            wait_cnt <= period_a;
          end else if (step_req) begin
            state <= S_COMMIT;
          end
        end
        S_WAIT: begin
          if (!run_eff) begin
            state <= S_IDLE;
          end else if (wait_cnt == '0) begin
            state <= S_COMMIT;
          end else begin
            wait_cnt <= wait_cnt - PERIOD_W'(1);
          end
        end
        S_COMMIT: begin
          threshold              <= thr_s;
          decay                  <= decay_s;
          refractory_period      <= refr_s;
          feedback_scale         <= fb_s;
          external_input_current <= ext_s;
          period_a               <= period_s;
          state                  <= S_ENABLE;
        end
        S_ENABLE: begin
          step_count <= step_count + STEP_CNT_W'(1);
          state      <= S_SAMPLE;
        end
        S_SAMPLE: begin
          if (spike_in && spike_count != 8'hFF) spike_count <= spike_count + 8'd1;
          // The SAMPLE cycle doubles as the first wait cycle of the next
          // step, which keeps the pulse spacing at period+3.
          if (run_eff) begin
            if (period_a == '0) begin
              state <= S_COMMIT;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= period_a - PERIOD_W'(1);
            end
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Clear overrides any increment happening in the same cycle.
      if (clr_req) begin
        spike_count <= 8'd0;
        step_count  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rsnn_step_scheduler.sv
module tb_rsnn_step_scheduler;

  logic        clk, reset;
  logic        cfg_valid, cfg_ready;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        spike_in, neuron_enable, neuron_reset;
  logic [7:0]  threshold, decay, refractory_period, feedback_scale, external_input_current;
  logic [7:0]  spike_count;
  logic [15:0] step_count;
  logic        busy;
  logic [2:0]  state_dbg;

  rsnn_step_scheduler #(.PERIOD_W(8), .STEP_CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .spike_in(spike_in),
    .neuron_enable(neuron_enable), .neuron_reset(neuron_reset),
    .threshold(threshold), .decay(decay), .refractory_period(refractory_period),
    .feedback_scale(feedback_scale), .external_input_current(external_input_current),
    .spike_count(spike_count), .step_count(step_count),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_spike = 0;
  int last_wr_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A step is described by the absolute cycle of its enable pulse (m_en):
  // commit is the cycle before, sample the cycle after, and everything
  // earlier while a step is pending is waiting time that run=0 can abort.
  logic [7:0]  m_sh [6];
  logic [7:0]  m_act[6];
  bit          m_on, m_run, m_nrst;
  int          m_en;
  logic [7:0]  m_spk;
  logic [15:0] m_stp;

  task automatic model_reset();
    m_sh[0] = 8'd64; m_sh[1] = 8'd2; m_sh[2] = 8'd4;
    m_sh[3] = 8'd0;  m_sh[4] = 8'd0; m_sh[5] = 8'd9;
    for (int i = 0; i < 6; i++) m_act[i] = m_sh[i];
    m_on = 0; m_run = 0; m_nrst = 0; m_en = 0;
    m_spk = 8'd0; m_stp = 16'd0;
  endtask

  task automatic model_step();
    bit acc, ctrl, run_eff, ss, clr;
    acc     = cfg_valid && !(m_on && cyc == m_en - 1);
    ctrl    = acc && cfg_addr == 3'd6;
    run_eff = ctrl ? cfg_data[0] : m_run;
    ss      = ctrl && cfg_data[1];
    clr     = ctrl && cfg_data[2];
    if (!m_on) begin
      if (acc && cfg_addr < 3'd6) begin
        m_sh[cfg_addr]  = cfg_data;
        m_act[cfg_addr] = cfg_data;
      end
      if (run_eff) begin
        m_on = 1; m_en = cyc + int'(m_act[5]) + 3;
      end else if (ss) begin
        m_on = 1; m_en = cyc + 2;
      end
    end else begin
      if (acc && cfg_addr < 3'd6) m_sh[cfg_addr] = cfg_data;
      if (cyc < m_en - 1) begin
        if (!run_eff) m_on = 0;
      end else if (cyc == m_en - 1) begin
        for (int i = 0; i < 6; i++) m_act[i] = m_sh[i];
      end else if (cyc == m_en) begin
        m_stp = m_stp + 16'd1;
      end else begin
        if (spike_in && m_spk != 8'd255) m_spk = m_spk + 8'd1;
        if (run_eff) m_en = m_en + int'(m_act[5]) + 3;
        else m_on = 0;
      end
    end
    m_run = run_eff;
    if (clr) begin m_spk = 8'd0; m_stp = 16'd0; end
    m_nrst = clr;
  endtask

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    if (reset) begin
      chk("neuron_reset_in_reset", neuron_reset, 1);
      model_reset();
    end else begin
      chk("neuron_enable", neuron_enable, int'(m_on && cyc == m_en));
      chk("cfg_ready", cfg_ready, int'(!(m_on && cyc == m_en - 1)));
      chk("busy", busy, int'(m_on));
      chk("idle_state", int'(state_dbg == 3'd0), int'(!m_on));
      chk("neuron_reset", neuron_reset, int'(m_nrst));
      chk("threshold", threshold, m_act[0]);
      chk("decay", decay, m_act[1]);
      chk("refractory_period", refractory_period, m_act[2]);
      chk("feedback_scale", feedback_scale, m_act[3]);
      chk("external_input_current", external_input_current, m_act[4]);
      chk("spike_count", spike_count, m_spk);
      chk("step_count", step_count, m_stp);
      model_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic nxt();
    @(posedge clk); #1;
    if (rand_spike) spike_in = 1'($urandom_range(0, 1));
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    bit done;
    done = 0;
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      if (cfg_ready) begin done = 1; last_wr_cyc = cyc; end
      nxt();
    end
    cfg_valid = 1'b0;
    if (!done) chk("cfg_write_timeout", 0, 1);
  endtask

  // Returns at the negedge of the next enable cycle.
  task automatic wait_enable(output int c);
    bit found;
    found = 0; c = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (neuron_enable) begin found = 1; c = cyc; end
    end
    if (!found) chk("wait_enable_timeout", 0, 1);
  endtask

  // Returns at the negedge of the next COMMIT cycle (cfg_ready low).
  task automatic wait_commit();
    bit found;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (!cfg_ready) found = 1;
    end
    if (!found) chk("wait_commit_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e1, e2, nb, ncommit, nen, ta, tb_c;
    bit seen;
    reset = 1'b1; cfg_valid = 1'b0; cfg_addr = 3'd0; cfg_data = 8'd0; spike_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values after five idle cycles.
    repeat (5) nxt();
    @(negedge clk);
    chk("rst_threshold", threshold, 64);
    chk("rst_decay", decay, 2);
    chk("rst_refr", refractory_period, 4);
    chk("rst_fb", feedback_scale, 0);
    chk("rst_ext", external_input_current, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enable", neuron_enable, 0);
    chk("rst_counts", int'(spike_count) + int'(step_count), 0);
    nxt();

    // Periodic run with period=2: first pulse 5 cycles after the ctrl write.
    cfg_write(3'd5, 8'd2);
    cfg_write(3'd6, 8'h01);
    wait_enable(e1);
    chk("first_pulse_latency", e1 - last_wr_cyc, 5);
    for (int k = 0; k < 3; k++) begin
      wait_enable(e2);
      chk("pulse_spacing_p2", e2 - e1, 5);
      e1 = e2;
    end
    nxt();
    @(negedge clk);
    chk("step_count_after_4", step_count, 4);
    nxt();

    // Threshold written mid-WAIT shows up only after COMMIT.
    cfg_write(3'd0, 8'd100);
    ncommit = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (!cfg_ready) begin
        ncommit++;
        chk("thr_in_commit", threshold, 64);
      end
      if (neuron_enable) begin
        seen = 1;
        chk("thr_in_enable", threshold, 100);
      end
    end
    chk("commit_ready_low_cycles", ncommit, 1);
    nxt();

    // Stop during WAIT: idle next cycle, no further pulses.
    nxt();
    cfg_write(3'd6, 8'h00);
    @(negedge clk);
    chk("stop_wait_idle", busy, 0);
    nen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (neuron_enable) nen++;
    end
    chk("stop_no_pulses", nen, 0);
    nxt();

    // Stop during ENABLE: SAMPLE still happens, then IDLE.
    cfg_write(3'd6, 8'h01);
    wait_commit();
    nxt();
    cfg_write(3'd6, 8'h00);
    @(negedge clk);
    chk("stop_enable_sample_busy", busy, 1);
    nxt();
    @(negedge clk);
    chk("stop_enable_then_idle", busy, 0);
    nxt();

    // Single steps with spike held high; count saturates at 255.
    spike_in = 1'b1;
    cfg_write(3'd6, 8'h04);
    for (int i = 0; i < 300; i++) begin
      cfg_write(3'd6, 8'h02);
      nb = 0; seen = 0;
      for (int j = 0; j < 10 && !seen; j++) begin
        @(negedge clk);
        if (busy) nb++; else seen = 1;
      end
      if (i == 0) begin
        chk("single_step_busy_cycles", nb, 3);
        chk("single_step_spike1", spike_count, 1);
      end
      nxt();
    end
    chk("spike_saturate", spike_count, 255);
    chk("step_count_300", step_count, 300);

    // run+clear written in SAMPLE while a spike is present: clear wins.
    cfg_write(3'd6, 8'h01);
    wait_commit();
    nxt();
    nxt();
    cfg_write(3'd6, 8'h05);
    @(negedge clk);
    chk("clear_spike0", spike_count, 0);
    chk("clear_step0", step_count, 0);
    chk("clear_nrst_hi", neuron_reset, 1);
    nxt();
    @(negedge clk);
    chk("clear_nrst_lo", neuron_reset, 0);
    wait_enable(e1);
    nxt();
    @(negedge clk);
    chk("resume_step1", step_count, 1);
    nxt();
    @(negedge clk);
    chk("resume_spike1", spike_count, 1);
    nxt();

    // Reset asserted in WAIT.
    wait_commit();
    nxt(); nxt(); nxt();
    reset = 1'b1;
    @(negedge clk);
    nxt();
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_thr", threshold, 64);
    chk("midreset_busy", busy, 0);
    chk("midreset_counts", int'(spike_count) + int'(step_count), 0);
    chk("midreset_enable", neuron_enable, 0);
    nxt();

    // Reset period (9) gives a 12-cycle pulse spacing.
    spike_in = 1'b0;
    cfg_write(3'd6, 8'h01);
    wait_enable(ta);
    wait_enable(tb_c);
    chk("pulse_spacing_p9", tb_c - ta, 12);
    nxt();
    cfg_write(3'd6, 8'h00);
    repeat (3) nxt();

    // Randomised traffic checked by the model every cycle.
    rand_spike = 1;
    for (int op = 0; op < 500; op++) begin
      int r;
      logic [2:0] a;
      logic [7:0] d;
      r = $urandom_range(0, 99);
      if (r < 15) begin
        a = 3'($urandom_range(0, 7));
        if (a == 3'd5) d = 8'($urandom_range(0, 6));
        else if (a == 3'd6) d = 8'($urandom_range(0, 1));
        else d = 8'($urandom);
        cfg_write(a, d);
      end else if (r < 22) begin
        cfg_write(3'd5, 8'($urandom_range(0, 6)));
      end else if (r < 45) begin
        d = 8'($urandom);
        d[0] = ($urandom_range(0, 3) != 0);
        d[2] = ($urandom_range(0, 7) == 0);
        cfg_write(3'd6, d);
      end else if (r < 47) begin
        reset = 1'b1;
        nxt();
        reset = 1'b0;
      end else begin
        repeat ($urandom_range(1, 8)) nxt();
      end
    end
    rand_spike = 0;
    spike_in = 1'b0;
    cfg_write(3'd6, 8'h00);
    repeat (30) nxt();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
